// File: rtl/lane_adder_pipe.sv
// Multi-lane adder/subtractor/accumulator with a registered output stage and
// a one-entry skid buffer; lanes are fully independent.
module lane_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             mode,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] sum,
  output logic [LANES-1:0]       carry
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ACC = 2'b10, OP_CLR = 2'b11} op_t;

  occ_t                   state;
  logic [LANES*WIDTH-1:0] skid_sum;
  logic [LANES-1:0]       skid_carry;
  logic [WIDTH-1:0]       acc     [LANES];
  logic [WIDTH-1:0]       acc_nxt [LANES];
  logic [LANES*WIDTH-1:0] res_sum;
  logic [LANES-1:0]       res_carry;
  logic [WIDTH:0]         t;
  logic [WIDTH-1:0]       ai, bi;
  logic                   accept, pop;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_comb begin
    res_sum   = '0;
    res_carry = '0;
    t         = '0;
    ai        = '0;
    bi        = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      acc_nxt[i] = acc[i];
      ai = a[i*WIDTH +: WIDTH];
      bi = b[i*WIDTH +: WIDTH];
      t  = '0;
      case (op_t'(mode))
        OP_ADD: begin
          t = {1'b0, ai} + {1'b0, bi};
          res_sum[i*WIDTH +: WIDTH] = t[WIDTH-1:0];
          res_carry[i] = t[WIDTH];
        end
        OP_SUB: begin
          // The extra bit is the borrow, so carry is its inverse.
          t = {1'b0, ai} - {1'b0, bi};
          res_sum[i*WIDTH +: WIDTH] = t[WIDTH-1:0];
          res_carry[i] = ~t[WIDTH];
        end
        OP_ACC: begin
          t = {1'b0, acc[i]} + {1'b0, ai};
          acc_nxt[i] = t[WIDTH-1:0];
          res_sum[i*WIDTH +: WIDTH] = t[WIDTH-1:0];
          res_carry[i] = t[WIDTH];
        end
        default: acc_nxt[i] = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < LANES; i++) acc[i] <= acc_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      sum        <= '0;
      carry      <= '0;
      skid_sum   <= '0;
      skid_carry <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            sum       <= res_sum;
            carry     <= res_carry;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            sum   <= res_sum;
            carry <= res_carry;
          end else if (accept) begin
            skid_sum   <= res_sum;
            skid_carry <= res_carry;
            in_ready   <= 1'b0;
            state      <= FULL;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so no accept can coincide with the pop.
          if (pop) begin
            sum      <= skid_sum;
            carry    <= skid_carry;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= EMPTY;
        end
      endcase
    end
  end

endmodule
